// File: rtl/regfile_scoreboard_pkg.sv
// Shared definitions for the register file / load-use scoreboard and for the
// decode and writeback stages that talk to it.
//   DW       : data width of one architectural register
//   AW       : register index width
//   NREG     : number of architectural registers (2**AW)
//   REG_ZERO : index of the hardwired-zero register
package regfile_scoreboard_pkg;

   localparam int DW   = 32;
   localparam int AW   = 5;
   localparam int NREG = 1 << AW;

   typedef logic [AW-1:0] reg_idx_t;
   typedef logic [DW-1:0] word_t;

   localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_sb_track.sv
// Load-use scoreboard: one pending bit per architectural register, set when
// decode issues a load to that destination and cleared when its writeback
// arrives. Also produces the decode stall.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   RegWrite, WriteReg     : writeback enable / index (clears pending)
//   issue_valid, issue_dest: load issue from decode (sets pending)
//   rd_reg1/2, rd_en1/2    : decode source indices and their use flags
//   stall                  : a used source is still pending
//   pending_mask           : current pending bits
module regfile_sb_track
   import regfile_scoreboard_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            RegWrite,
   input  logic [AW-1:0]   WriteReg,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_dest,
   input  logic [AW-1:0]   rd_reg1,
   input  logic [AW-1:0]   rd_reg2,
   input  logic            rd_en1,
   input  logic            rd_en2,
   output logic            stall,
   output logic [NREG-1:0] pending_mask
);

   logic [NREG-1:0] pending_reg;
   logic [NREG-1:0] pending_next;
   logic            hit1;
   logic            hit2;

   // A pending source being written back this very cycle does not stall:
   // the read port bypasses wb_data for it.
   assign hit1 = rd_en1 && (rd_reg1 != REG_ZERO) && pending_reg[rd_reg1]
                 && !(RegWrite && (WriteReg == rd_reg1));
   assign hit2 = rd_en2 && (rd_reg2 != REG_ZERO) && pending_reg[rd_reg2]
                 && !(RegWrite && (WriteReg == rd_reg2));
   assign stall = hit1 || hit2;

   // Register 0 never holds a value, so it can never be pending.
   assign pending_next[0] = 1'b0;

   genvar gi;
   generate
      for (gi = 1; gi < NREG; gi++) begin : g_bit
         logic set_bit;
         logic clr_bit;
         // A stalled instruction is not issued, so it must not set a bit.
         assign set_bit = issue_valid && !stall && (issue_dest == reg_idx_t'(gi));
         assign clr_bit = RegWrite && (WriteReg == reg_idx_t'(gi));
         // Set wins: the writeback belongs to an older instruction while the
         // newly issued load is still in flight.
         assign pending_next[gi] = set_bit ? 1'b1 :
                                   (clr_bit ? 1'b0 : pending_reg[gi]);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_reg <= '0;
      end else begin
         pending_reg <= pending_next;
      end
   end

   assign pending_mask = pending_reg;

endmodule

// File: rtl/regfile_scoreboard.sv
// Architectural register file with load-use scoreboard.
// Two combinational read ports with same-cycle writeback bypass; register 0
// reads as zero and ignores writes.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   RegWrite/WriteReg/wb_data : writeback stage write port
//   rd_reg1/2, rd_en1/2    : decode read indices and operand-used flags
//   rd_data1/2             : read data
//   issue_valid/issue_dest : decode issuing a load to issue_dest
//   stall                  : decode must hold
//   pending_mask           : scoreboard bits (debug)
module regfile_scoreboard
   import regfile_scoreboard_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            RegWrite,
   input  logic [AW-1:0]   WriteReg,
   input  logic [DW-1:0]   wb_data,
   input  logic [AW-1:0]   rd_reg1,
   input  logic [AW-1:0]   rd_reg2,
   input  logic            rd_en1,
   input  logic            rd_en2,
   output logic [DW-1:0]   rd_data1,
   output logic [DW-1:0]   rd_data2,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_dest,
   output logic            stall,
   output logic [NREG-1:0] pending_mask
);

   // Full reset of the contents is required, so this is a flop array
   // rather than a RAM.
   word_t regs_reg [NREG];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs_reg[i] <= '0;
         end
      end else if (RegWrite && (WriteReg != REG_ZERO)) begin
         regs_reg[WriteReg] <= wb_data;
      end
   end

   always_comb begin
      rd_data1 = regs_reg[rd_reg1];
      if (rd_reg1 == REG_ZERO) begin
         rd_data1 = '0;
      end else if (RegWrite && (WriteReg == rd_reg1)) begin
         rd_data1 = wb_data;
      end
   end

   always_comb begin
      rd_data2 = regs_reg[rd_reg2];
      if (rd_reg2 == REG_ZERO) begin
         rd_data2 = '0;
      end else if (RegWrite && (WriteReg == rd_reg2)) begin
         rd_data2 = wb_data;
      end
   end

   regfile_sb_track u_track (
      .clk          (clk),
      .rst          (rst),
      .RegWrite     (RegWrite),
      .WriteReg     (WriteReg),
      .issue_valid  (issue_valid),
      .issue_dest   (issue_dest),
      .rd_reg1      (rd_reg1),
      .rd_reg2      (rd_reg2),
      .rd_en1       (rd_en1),
      .rd_en2       (rd_en2),
      .stall        (stall),
      .pending_mask (pending_mask)
   );

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

   logic        clk;
   logic        rst;
   logic        RegWrite;
   logic [4:0]  WriteReg;
   logic [31:0] wb_data;
   logic [4:0]  rd_reg1;
   logic [4:0]  rd_reg2;
   logic        rd_en1;
   logic        rd_en2;
   logic [31:0] rd_data1;
   logic [31:0] rd_data2;
   logic        issue_valid;
   logic [4:0]  issue_dest;
   logic        stall;
   logic [31:0] pending_mask;

   typedef struct packed {
      logic [31:0] d1;
      logic [31:0] d2;
      logic        st;
      logic [31:0] mask;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   checks;
   int   failures;

   regfile_scoreboard dut (
      .clk          (clk),
      .rst          (rst),
      .RegWrite     (RegWrite),
      .WriteReg     (WriteReg),
      .wb_data      (wb_data),
      .rd_reg1      (rd_reg1),
      .rd_reg2      (rd_reg2),
      .rd_en1       (rd_en1),
      .rd_en2       (rd_en2),
      .rd_data1     (rd_data1),
      .rd_data2     (rd_data2),
      .issue_valid  (issue_valid),
      .issue_dest   (issue_dest),
      .stall        (stall),
      .pending_mask (pending_mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle();
      RegWrite    = 1'b0;
      WriteReg    = '0;
      wb_data     = '0;
      rd_reg1     = '0;
      rd_reg2     = '0;
      rd_en1      = 1'b0;
      rd_en2      = 1'b0;
      issue_valid = 1'b0;
      issue_dest  = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      // rst must override a same-cycle write and issue
      idle();
      rst = 1'b1;
      RegWrite = 1'b1; WriteReg = 5'd5; wb_data = 32'hFFFF_FFFF;
      issue_valid = 1'b1; issue_dest = 5'd31;
      tick();
      rst = 1'b0;
      idle();
      rd_reg1 = 5'd5; rd_reg2 = 5'd31; rd_en1 = 1'b1; rd_en2 = 1'b1;
      exp_q.push_back('{d1: 32'h0, d2: 32'h0, st: 1'b0, mask: 32'h0});
      @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (rd_data1 !== e.d1) begin failures++; $display("FAIL reset_rd1 got=%h exp=%h", rd_data1, e.d1); end
      checks++; if (rd_data2 !== e.d2) begin failures++; $display("FAIL reset_rd2 got=%h exp=%h", rd_data2, e.d2); end
      checks++; if (stall !== e.st) begin failures++; $display("FAIL reset_stall got=%b exp=%b", stall, e.st); end
      checks++; if (pending_mask !== e.mask) begin failures++; $display("FAIL reset_mask got=%h exp=%h", pending_mask, e.mask); end
      $display("reset: rd1=%h rd2=%h stall=%b mask=%h", rd_data1, rd_data2, stall, pending_mask);
      tick();
   endtask

   task automatic test_write_bypass();
      // {RegWrite, WriteReg, wb_data, rd_reg1, rd_reg2, exp1, exp2}
      logic        we_t [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      logic [4:0]  wr_t [4] = '{5'd7, 5'd20, 5'd7, 5'd0};
      logic [31:0] wd_t [4] = '{32'hDEADBEEF, 32'h11112222, 32'hCAFEF00D, 32'h0};
      logic [4:0]  r1_t [4] = '{5'd7, 5'd7, 5'd7, 5'd7};
      logic [4:0]  r2_t [4] = '{5'd7, 5'd7, 5'd20, 5'd20};
      logic [31:0] e1_t [4] = '{32'hDEADBEEF, 32'hDEADBEEF, 32'hCAFEF00D, 32'hCAFEF00D};
      logic [31:0] e2_t [4] = '{32'hDEADBEEF, 32'hDEADBEEF, 32'h11112222, 32'h11112222};
      for (int i = 0; i < 4; i++) begin
         idle();
         RegWrite = we_t[i]; WriteReg = wr_t[i]; wb_data = wd_t[i];
         rd_reg1 = r1_t[i]; rd_reg2 = r2_t[i];
         exp_q.push_back('{d1: e1_t[i], d2: e2_t[i], st: 1'b0, mask: 32'h0});
         @(negedge clk);
         e = exp_q.pop_front();
         checks++; if (rd_data1 !== e.d1) begin failures++; $display("FAIL wr_rd1[%0d] got=%h exp=%h", i, rd_data1, e.d1); end
         checks++; if (rd_data2 !== e.d2) begin failures++; $display("FAIL wr_rd2[%0d] got=%h exp=%h", i, rd_data2, e.d2); end
         $display("write[%0d]: we=%b wr=%0d wd=%h rd1=%h rd2=%h", i, RegWrite, WriteReg, wb_data, rd_data1, rd_data2);
         tick();
      end
   endtask

   task automatic test_zero_reg();
      for (int i = 0; i < 2; i++) begin
         idle();
         if (i == 0) begin
            RegWrite = 1'b1; WriteReg = 5'd0; wb_data = 32'h1234;
         end
         exp_q.push_back('{d1: 32'h0, d2: 32'h0, st: 1'b0, mask: 32'h0});
         @(negedge clk);
         e = exp_q.pop_front();
         checks++; if (rd_data1 !== e.d1) begin failures++; $display("FAIL zero_rd1[%0d] got=%h exp=%h", i, rd_data1, e.d1); end
         checks++; if (pending_mask !== e.mask) begin failures++; $display("FAIL zero_mask[%0d] got=%h exp=%h", i, pending_mask, e.mask); end
         $display("zero[%0d]: rd1=%h mask=%h", i, rd_data1, pending_mask);
         tick();
      end
   endtask

   task automatic test_load_use();
      // cycle: 0 issue 9; 1,2 used source 9; 3 unused; 4 writeback; 5 after
      logic [31:0] em_t [6] = '{32'h0, 32'h200, 32'h200, 32'h200, 32'h200, 32'h0};
      logic        es_t [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 6; i++) begin
         idle();
         rd_reg2 = 5'd9;
         case (i)
            0: begin issue_valid = 1'b1; issue_dest = 5'd9; rd_reg2 = 5'd0; end
            1, 2: rd_en2 = 1'b1;
            3: rd_en2 = 1'b0;
            4: begin rd_en2 = 1'b1; RegWrite = 1'b1; WriteReg = 5'd9; wb_data = 32'hA5A5A5A5; end
            default: rd_en2 = 1'b1;
         endcase
         exp_q.push_back('{d1: 32'h0, d2: (i >= 4) ? 32'hA5A5A5A5 : 32'h0, st: es_t[i], mask: em_t[i]});
         @(negedge clk);
         e = exp_q.pop_front();
         checks++; if (stall !== e.st) begin failures++; $display("FAIL lu_stall[%0d] got=%b exp=%b", i, stall, e.st); end
         checks++; if (pending_mask !== e.mask) begin failures++; $display("FAIL lu_mask[%0d] got=%h exp=%h", i, pending_mask, e.mask); end
         if (i >= 4) begin
            checks++; if (rd_data2 !== e.d2) begin failures++; $display("FAIL lu_rd2[%0d] got=%h exp=%h", i, rd_data2, e.d2); end
         end
         $display("load_use[%0d]: stall=%b mask=%h rd2=%h", i, stall, pending_mask, rd_data2);
         tick();
      end
   endtask

   task automatic test_set_clear();
      // 0 issue 4; 1 issue 4 + writeback 4; 2 read 4 still pending; 3 clear; 4 idle
      logic [31:0] em_t [5] = '{32'h0, 32'h10, 32'h10, 32'h10, 32'h0};
      for (int i = 0; i < 5; i++) begin
         idle();
         rd_reg1 = 5'd4;
         case (i)
            0: begin issue_valid = 1'b1; issue_dest = 5'd4; end
            1: begin issue_valid = 1'b1; issue_dest = 5'd4;
                     RegWrite = 1'b1; WriteReg = 5'd4; wb_data = 32'h44444444; end
            3: begin RegWrite = 1'b1; WriteReg = 5'd4; wb_data = 32'h44444444; end
            default: ;
         endcase
         exp_q.push_back('{d1: (i >= 1) ? 32'h44444444 : 32'h0, d2: 32'h0, st: 1'b0, mask: em_t[i]});
         @(negedge clk);
         e = exp_q.pop_front();
         checks++; if (pending_mask !== e.mask) begin failures++; $display("FAIL sc_mask[%0d] got=%h exp=%h", i, pending_mask, e.mask); end
         checks++; if (rd_data1 !== e.d1) begin failures++; $display("FAIL sc_rd1[%0d] got=%h exp=%h", i, rd_data1, e.d1); end
         $display("set_clear[%0d]: mask=%h rd1=%h", i, pending_mask, rd_data1);
         tick();
      end
   endtask

   task automatic test_issue_stalled();
      // 0 issue 3; 1 stalled issue 12; 2 redundant issue 3 + clear of idle 12;
      // 3 clear 3; 4 idle
      logic [31:0] em_t [5] = '{32'h0, 32'h8, 32'h8, 32'h8, 32'h0};
      logic        es_t [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 5; i++) begin
         idle();
         case (i)
            0: begin issue_valid = 1'b1; issue_dest = 5'd3; end
            1: begin rd_reg1 = 5'd3; rd_en1 = 1'b1; issue_valid = 1'b1; issue_dest = 5'd12; end
            2: begin issue_valid = 1'b1; issue_dest = 5'd3;
                     RegWrite = 1'b1; WriteReg = 5'd12; wb_data = 32'h0C0C0C0C; end
            3: begin RegWrite = 1'b1; WriteReg = 5'd3; wb_data = 32'h33333333; end
            default: ;
         endcase
         exp_q.push_back('{d1: 32'h0, d2: 32'h0, st: es_t[i], mask: em_t[i]});
         @(negedge clk);
         e = exp_q.pop_front();
         checks++; if (stall !== e.st) begin failures++; $display("FAIL is_stall[%0d] got=%b exp=%b", i, stall, e.st); end
         checks++; if (pending_mask !== e.mask) begin failures++; $display("FAIL is_mask[%0d] got=%h exp=%h", i, pending_mask, e.mask); end
         $display("issue_stalled[%0d]: stall=%b mask=%h", i, stall, pending_mask);
         tick();
      end
   endtask

   task automatic test_reset_mid();
      // 0 issue 9; 1 issue 10; 2 check 0x600; 3 rst with stall+issue; 4 after
      logic [31:0] em_t [5] = '{32'h0, 32'h200, 32'h600, 32'h600, 32'h0};
      logic        es_t [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 5; i++) begin
         idle();
         rst = 1'b0;
         case (i)
            0: begin issue_valid = 1'b1; issue_dest = 5'd9; end
            1: begin issue_valid = 1'b1; issue_dest = 5'd10; end
            3: begin rst = 1'b1; rd_reg1 = 5'd9; rd_en1 = 1'b1;
                     issue_valid = 1'b1; issue_dest = 5'd5; end
            4: begin rd_reg1 = 5'd9; rd_en1 = 1'b1; end
            default: ;
         endcase
         exp_q.push_back('{d1: 32'h0, d2: 32'h0, st: es_t[i], mask: em_t[i]});
         @(negedge clk);
         e = exp_q.pop_front();
         checks++; if (stall !== e.st) begin failures++; $display("FAIL rm_stall[%0d] got=%b exp=%b", i, stall, e.st); end
         checks++; if (pending_mask !== e.mask) begin failures++; $display("FAIL rm_mask[%0d] got=%h exp=%h", i, pending_mask, e.mask); end
         if (i == 4) begin
            checks++; if (rd_data1 !== e.d1) begin failures++; $display("FAIL rm_rd1 got=%h exp=%h", rd_data1, e.d1); end
         end
         $display("reset_mid[%0d]: rst=%b stall=%b mask=%h rd1=%h", i, rst, stall, pending_mask, rd_data1);
         tick();
      end
      rst = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b0;
      idle();
      test_reset();
      test_write_bypass();
      test_zero_reg();
      test_load_use();
      test_set_clear();
      test_issue_stalled();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
